// File: rtl/armleocpu_ptw_arbiter_pkg.sv
// Shared definitions for the page table walker arbiter.
//   - ptw_arb_state_t : 2-bit FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   - REQ_INST/REQ_DATA: requester indices (0 = fetch MMU, 1 = load/store MMU)
package armleocpu_ptw_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ptw_arb_state_t;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

endpackage

// File: rtl/armleocpu_rr_arbiter2.sv
// Combinational two-input picker.
//   valid[1:0]  : pending requests (bit 0 = instruction, bit 1 = data)
//   last_grant  : index granted most recently (round-robin history)
//   grant       : winning index, meaningful only when any_grant is high
//   any_grant   : at least one request pending
// FIXED_PRIORITY=0 alternates on a tie; FIXED_PRIORITY=1 lets data win every tie.
module armleocpu_rr_arbiter2
    import armleocpu_ptw_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_grant
);

    always_comb begin
        any_grant = |valid;
        grant     = REQ_INST;
        if (valid == 2'b11) begin
            // Tie: fixed mode favours data, round-robin favours whoever did not go last.
            grant = (FIXED_PRIORITY != 0) ? REQ_DATA : ~last_grant;
        end else if (valid[REQ_DATA]) begin
            grant = REQ_DATA;
        end
    end

endmodule

// File: rtl/armleocpu_ptw_arbiter.sv
// Shares one SV32 page table walker between the instruction and data MMUs.
// One walk is in flight at a time; the walker result is registered and a
// one-cycle done strobe goes to the requester that owns the walk.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req0_* / req1_*            : level requests + 20-bit VPN from inst / data MMU
//   rsp0_done / rsp1_done      : one-cycle result strobe per requester
//   rsp_*                      : registered walk result shared by both requesters
//   ptw_resolve_request/
//   ptw_virtual_address        : registered request to the walker
//   ptw_resolve_*              : walker result, done is combinational from walker
//   busy                       : high whenever the FSM is not in IDLE
module armleocpu_ptw_arbiter
    import armleocpu_ptw_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    input  logic [19:0] req0_vaddr,
    input  logic        req1_valid,
    input  logic [19:0] req1_vaddr,

    output logic        rsp0_done,
    output logic        rsp1_done,
    output logic        rsp_pagefault,
    output logic        rsp_accessfault,
    output logic [7:0]  rsp_metadata,
    output logic [21:0] rsp_physical_address,

    output logic        ptw_resolve_request,
    output logic [19:0] ptw_virtual_address,
    input  logic        ptw_resolve_done,
    input  logic        ptw_resolve_pagefault,
    input  logic        ptw_resolve_accessfault,
    input  logic [7:0]  ptw_resolve_metadata,
    input  logic [21:0] ptw_resolve_physical_address,

    output logic        busy
);

    ptw_arb_state_t state, state_n;

    logic       owner;
    logic       last_grant;
    logic       grant;
    logic       any_grant;
    logic       grant_en;
    logic       capture_en;
    logic [1:0] req_valid;

    assign req_valid = {req1_valid, req0_valid};

    armleocpu_rr_arbiter2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any_grant  (any_grant)
    );

    always_comb begin
        state_n    = state;
        grant_en   = 1'b0;
        capture_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_grant) begin
                    grant_en = 1'b1;
                    state_n  = ST_ISSUE;
                end
            end
            // Walker is idle here and samples the request; one cycle only.
            ST_ISSUE: state_n = ST_WAIT;
            // A done seen in any other state is ignored: only WAIT listens.
            ST_WAIT: begin
                if (ptw_resolve_done) begin
                    capture_en = 1'b1;
                    state_n    = ST_RESP;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner                <= REQ_INST;
            // Data marked as last so the first tie after reset goes to fetch.
            last_grant           <= REQ_DATA;
            ptw_resolve_request  <= 1'b0;
            ptw_virtual_address  <= 20'd0;
            rsp_pagefault        <= 1'b0;
            rsp_accessfault      <= 1'b0;
            rsp_metadata         <= 8'd0;
            rsp_physical_address <= 22'd0;
        end else begin
            // High exactly for the ISSUE cycle.
            ptw_resolve_request <= grant_en;
            if (grant_en) begin
                owner               <= grant;
                last_grant          <= grant;
                ptw_virtual_address <= grant ? req1_vaddr : req0_vaddr;
            end
            if (capture_en) begin
                rsp_pagefault        <= ptw_resolve_pagefault;
                rsp_accessfault      <= ptw_resolve_accessfault;
                rsp_metadata         <= ptw_resolve_metadata;
                rsp_physical_address <= ptw_resolve_physical_address;
            end
        end
    end

    // An owner that withdrew during the walk gets no strobe; result is dropped.
    assign rsp0_done = (state == ST_RESP) && (owner == REQ_INST) && req0_valid;
    assign rsp1_done = (state == ST_RESP) && (owner == REQ_DATA) && req1_valid;
    assign busy      = (state != ST_IDLE);

`ifdef DEBUG_PTW_ARB
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(ptw_resolve_done && state != ST_WAIT))
                else $error("ptw_resolve_done outside WAIT");
        end
    end
`endif

endmodule

// File: tb/tb_armleocpu_ptw_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share
// the requester inputs; each has its own walker model with programmable latency.
module tb_armleocpu_ptw_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [19:0] req0_vaddr, req1_vaddr;
    logic        w_pf, w_af, stray;
    logic [7:0]  w_meta;
    logic [21:0] w_pa;
    logic [1:0]  w_done;

    logic [1:0]  o_r0, o_r1, o_pf, o_af, o_req, o_busy;
    logic [7:0]  o_meta [2];
    logic [21:0] o_pa   [2];
    logic [19:0] o_pva  [2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 5;
    int wcnt [2];
    int rr_req_hi = 0;
    int both_hi = 0;

    logic [19:0] rr_walks[$], fp_walks[$];
    int          rr_dones[$], fp_dones[$];
    logic [31:0] rr_rsp[$];
    int          rr_req_cyc[$], rr_wdone_cyc[$], rr_rsp_cyc[$];

    always #5 clk = ~clk;

    armleocpu_ptw_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_vaddr(req0_vaddr),
        .req1_valid(req1_valid), .req1_vaddr(req1_vaddr),
        .rsp0_done(o_r0[0]), .rsp1_done(o_r1[0]),
        .rsp_pagefault(o_pf[0]), .rsp_accessfault(o_af[0]),
        .rsp_metadata(o_meta[0]), .rsp_physical_address(o_pa[0]),
        .ptw_resolve_request(o_req[0]), .ptw_virtual_address(o_pva[0]),
        .ptw_resolve_done(w_done[0] | stray),
        .ptw_resolve_pagefault(w_pf), .ptw_resolve_accessfault(w_af),
        .ptw_resolve_metadata(w_meta), .ptw_resolve_physical_address(w_pa),
        .busy(o_busy[0])
    );

    armleocpu_ptw_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_vaddr(req0_vaddr),
        .req1_valid(req1_valid), .req1_vaddr(req1_vaddr),
        .rsp0_done(o_r0[1]), .rsp1_done(o_r1[1]),
        .rsp_pagefault(o_pf[1]), .rsp_accessfault(o_af[1]),
        .rsp_metadata(o_meta[1]), .rsp_physical_address(o_pa[1]),
        .ptw_resolve_request(o_req[1]), .ptw_virtual_address(o_pva[1]),
        .ptw_resolve_done(w_done[1] | stray),
        .ptw_resolve_pagefault(w_pf), .ptw_resolve_accessfault(w_af),
        .ptw_resolve_metadata(w_meta), .ptw_resolve_physical_address(w_pa),
        .busy(o_busy[1])
    );

    // Monitor then walker model, in one process so their order is fixed.
    // The walker sees the request in the ISSUE cycle and raises done 'lat' cycles later.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt[0] = 0;
            wcnt[1] = 0;
            w_done  = 2'b00;
        end else begin
            cyc++;
            if ((o_r0 & o_r1) != 2'b00) both_hi++;
            if (o_req[0]) begin
                rr_walks.push_back(o_pva[0]);
                rr_req_cyc.push_back(cyc);
                rr_req_hi++;
            end
            if (o_req[1]) fp_walks.push_back(o_pva[1]);
            if (o_r0[0] || o_r1[0]) begin
                rr_dones.push_back(o_r1[0] ? 1 : 0);
                rr_rsp.push_back({o_pf[0], o_af[0], o_meta[0], o_pa[0]});
                rr_rsp_cyc.push_back(cyc);
            end
            if (o_r0[1] || o_r1[1]) fp_dones.push_back(o_r1[1] ? 1 : 0);
            for (int i = 0; i < 2; i++) begin
                w_done[i] = 1'b0;
                if (o_req[i]) wcnt[i] = lat;
                else if (wcnt[i] > 0) begin
                    wcnt[i]--;
                    if (wcnt[i] == 0) w_done[i] = 1'b1;
                end
            end
            if (w_done[0]) rr_wdone_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        rr_walks.delete(); fp_walks.delete();
        rr_dones.delete(); fp_dones.delete();
        rr_rsp.delete(); rr_req_cyc.delete();
        rr_wdone_cyc.delete(); rr_rsp_cyc.delete();
        rr_req_hi = 0;
    endtask

    // Returns #1 into the cycle after the n-th done pulse (the IDLE cycle).
    task automatic wait_dones(input int inst, input int n, input string tag);
        int b = 0;
        while (((inst == 0) ? rr_dones.size() : fp_dones.size()) < n && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        chk(tag, 32'(((inst == 0) ? rr_dones.size() : fp_dones.size()) >= n), 1);
    endtask

    task automatic wait_idle(input string tag);
        int b = 0;
        while ((|o_busy) && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        chk(tag, 32'(|o_busy), 0);
    endtask

    task automatic wait_walk(input string tag);
        int b = 0;
        while (rr_walks.size() < 1 && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        chk(tag, rr_walks.size(), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_vaddr = '0; req1_vaddr = '0;
        w_pf = 1'b0; w_af = 1'b0; w_meta = '0; w_pa = '0; stray = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_req", 32'(o_req), 0);
        chk("rst_va", o_pva[0], 0);
        chk("rst_meta", o_meta[0], 0);
        chk("rst_pa", o_pa[0], 0);
        chk("rst_done", 32'({o_r0, o_r1}), 0);
        rst_n = 1'b1;

        // Single instruction-side walk, walker latency 5
        clr();
        lat = 5; w_meta = 8'hCF; w_pa = 22'h0ABCDE;
        req0_vaddr = 20'h12345; req0_valid = 1'b1; t0 = cyc + 1;
        wait_dones(0, 1, "t1_wait");
        req0_valid = 1'b0;
        wait_idle("t1_idle");
        chk("t1_nwalk", rr_walks.size(), 1);
        chk("t1_va", rr_walks[0], 20'h12345);
        chk("t1_reqlen", rr_req_hi, 1);
        chk("t1_issue_lat", rr_req_cyc[0] - t0, 1);
        chk("t1_walk_lat", rr_wdone_cyc[0] - rr_req_cyc[0], 5);
        chk("t1_rsp_lat", rr_rsp_cyc[0] - rr_wdone_cyc[0], 1);
        chk("t1_ndone", rr_dones.size(), 1);
        chk("t1_who", rr_dones[0], 0);
        chk("t1_meta", rr_rsp[0][29:22], 8'hCF);
        chk("t1_pa", rr_rsp[0][21:0], 22'h0ABCDE);
        chk("t1_hold_meta", o_meta[0], 8'hCF);

        // Tie from reset: round-robin alternates, fixed priority always picks data
        rst_n = 1'b0; #10; rst_n = 1'b1;
        clr();
        lat = 2;
        req0_vaddr = 20'h00001; req1_vaddr = 20'h00002;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_dones(0, 3, "t2_wait");
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("t2_idle");
        chk("t2_rr_va0", rr_walks[0], 20'h00001);
        chk("t2_rr_va1", rr_walks[1], 20'h00002);
        chk("t2_rr_va2", rr_walks[2], 20'h00001);
        chk("t2_rr_order", 32'({rr_dones[0][1:0], rr_dones[1][1:0], rr_dones[2][1:0]}), 32'b00_01_00);
        chk("t2_fp_va", 32'({fp_walks[0], fp_walks[1], fp_walks[2]} == {3{20'h00002}}), 1);
        chk("t2_fp_order", 32'({fp_dones[0][1:0], fp_dones[1][1:0], fp_dones[2][1:0]}), 32'b01_01_01);

        // Fixed priority: req0 waits until req1 drops
        clr();
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_dones(1, 2, "t2b_wait1");
        req1_valid = 1'b0;
        wait_dones(1, 3, "t2b_wait2");
        req0_valid = 1'b0;
        wait_idle("t2b_idle");
        chk("t2b_fp_order", 32'({fp_dones[0][1:0], fp_dones[1][1:0], fp_dones[2][1:0]}), 32'b01_01_00);
        chk("t2b_fp_va2", fp_walks[2], 20'h00001);

        // Fault flags reach the registered outputs
        clr();
        lat = 3;
        w_pf = 1'b0; w_af = 1'b1; w_meta = 8'h5A; w_pa = 22'h155555;
        req1_vaddr = 20'h0AAAA; req1_valid = 1'b1;
        wait_dones(0, 1, "t3_wait1");
        req1_valid = 1'b0;
        wait_idle("t3_idle1");
        w_pf = 1'b1; w_af = 1'b0; w_meta = 8'h33; w_pa = 22'h2AAAAA;
        req0_vaddr = 20'h0F00F; req0_valid = 1'b1;
        wait_dones(0, 2, "t3_wait2");
        req0_valid = 1'b0;
        wait_idle("t3_idle2");
        chk("t3_who", 32'({rr_dones[0][1:0], rr_dones[1][1:0]}), 32'b01_00);
        chk("t3_flags_af", rr_rsp[0][31:30], 2'b01);
        chk("t3_pa_af", rr_rsp[0][21:0], 22'h155555);
        chk("t3_flags_pf", rr_rsp[1][31:30], 2'b10);
        chk("t3_meta_pf", rr_rsp[1][29:22], 8'h33);

        // Data requester withdraws mid-walk; pending req0 follows right after RESP
        clr();
        lat = 5;
        req1_vaddr = 20'h0BBBB; req1_valid = 1'b1;
        wait_walk("t4_issue");
        req0_vaddr = 20'h0CCCC; req0_valid = 1'b1;
        req1_vaddr = 20'hFFFFF;
        repeat (2) begin @(posedge clk); #1; end
        chk("t4_hold_va", o_pva[0], 20'h0BBBB);
        req1_valid = 1'b0;
        wait_dones(0, 1, "t4_wait");
        req0_valid = 1'b0;
        wait_idle("t4_idle");
        chk("t4_ndone", rr_dones.size(), 1);
        chk("t4_who", rr_dones[0], 0);
        chk("t4_va1", rr_walks[1], 20'h0CCCC);
        chk("t4_regrant_lat", rr_req_cyc[1] - rr_wdone_cyc[0], 3);
        chk("t4_fp_ndone", fp_dones.size(), 1);

        // Stray walker done while idle is ignored
        clr();
        w_meta = 8'hEE;
        @(posedge clk); #1; stray = 1'b1;
        @(posedge clk); #1; stray = 1'b0;
        @(posedge clk); #1;
        chk("t5_busy", 32'(o_busy), 0);
        chk("t5_meta", o_meta[0], 8'h33);
        chk("t5_nodone", rr_dones.size() + fp_dones.size(), 0);

        // Asynchronous reset in the middle of WAIT
        clr();
        req0_vaddr = 20'h00111; req1_vaddr = 20'h00222;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_walk("t6_issue");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(o_busy), 0);
        chk("t6_req", 32'(o_req), 0);
        chk("t6_va", 32'({o_pva[0], o_pva[1]} != 40'd0), 0);
        chk("t6_rsp", 32'({o_pf, o_af, o_meta[0], o_pa[0]} != 34'd0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr();
        wait_dones(0, 1, "t6_wait");
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("t6_idle");
        chk("t6_rr_first", rr_walks[0], 20'h00111);
        chk("t6_rr_who", rr_dones[0], 0);
        chk("t6_fp_first", fp_walks[0], 20'h00222);

        chk("no_dual_done", both_hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
